// File: rtl/mxu_pkg.sv
// Shared sizing defaults, FSM state type and small helpers for the MXU feeder.
package mxu_pkg;

  localparam int LOG_ALLOWED_PRECISIONS = 3;
  localparam int M_DEF                  = 4;
  localparam int K_DEF                  = 4;
  localparam int LANE_W_DEF             = 64;
  localparam int MXU_LATENCY_DEF        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    READY   = 3'd2,
    COMPUTE = 3'd3,
    RESULT  = 3'd4
  } feeder_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxu_feeder_if.sv
// System-side streams of the MXU feeder: weight rows in, activations in, results out.
interface mxu_feeder_if #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int W = 64
);
  logic           w_valid;
  logic           w_ready;
  logic [K*W-1:0] w_data;
  logic           a_valid;
  logic           a_ready;
  logic [M*W-1:0] a_data;
  logic           r_valid;
  logic           r_ready;
  logic [K*W-1:0] r_data;

  modport master (
    output w_valid, w_data, a_valid, a_data, r_ready,
    input  w_ready, a_ready, r_valid, r_data
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data, r_ready,
    output w_ready, a_ready, r_valid, r_data
  );
endinterface

// File: rtl/mxu_weight_buffer.sv
// Stationary weight store: row counter plus M rows of K lanes, written one row per beat.
module mxu_weight_buffer
  import mxu_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 4,
  parameter int W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             restart,
  input  logic [K*W-1:0]   row_data,
  output logic [M*K*W-1:0] weight,
  output logic             wr_last
);
  localparam int RW = cnt_w(M);

  logic [RW-1:0]             row_cnt;
  logic [RW-1:0]             row_idx;
  logic [M-1:0][K*W-1:0]     rows;

  // A new load always begins at row 0 regardless of where the counter sits.
  assign row_idx = restart ? '0 : row_cnt;
  assign wr_last = (row_idx == RW'(M-1));
  assign weight  = rows;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      rows    <= '0;
    end else if (wr_en) begin
      row_cnt <= wr_last ? '0 : row_idx + RW'(1);
      for (int i = 0; i < M; i++) begin
        if (row_idx == RW'(i)) rows[i] <= row_data;
      end
    end
  end

endmodule

// File: rtl/mxu_feeder.sv
// Feeds the MXU: loads stationary weights, runs one activation through the fixed latency,
// returns y on a result stream. Optional perf counters under MXU_FEEDER_PERF_EN.
module mxu_feeder
  import mxu_pkg::*;
#(
  parameter int M              = M_DEF,
  parameter int K              = K_DEF,
  parameter int MAX_DATA_WIDTH = LANE_W_DEF,
  parameter int MXU_LATENCY    = MXU_LATENCY_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LOG_ALLOWED_PRECISIONS-1:0] cfg_data_type,
  input  logic [1:0]                        cfg_fp_unit,
  mxu_feeder_if.slave                       bus,
  output logic [LOG_ALLOWED_PRECISIONS-1:0] mxu_data_type,
  output logic                              mxu_enable,
  output logic                              mxu_enable_in_ff,
  output logic                              mxu_enable_out_ff,
  output logic                              mxu_enable_chain,
  output logic [1:0]                        mxu_enable_fp_unit,
  output logic                              mxu_test_mode,
  output logic [M*MAX_DATA_WIDTH-1:0]       mxu_input_data,
  output logic [M*K*MAX_DATA_WIDTH-1:0]     mxu_weight,
  input  logic [K*MAX_DATA_WIDTH-1:0]       mxu_y
`ifdef MXU_FEEDER_PERF_EN
  ,
  output logic [31:0]                       perf_ops,
  output logic [31:0]                       perf_busy
`endif
);
  localparam int W  = MAX_DATA_WIDTH;
  localparam int LW = cnt_w(MXU_LATENCY);

  feeder_state_t  state, state_nxt;
  logic [LW-1:0]  lat_cnt;
  logic           weights_valid;
  logic           lat_last;
  logic           w_acc, a_acc, r_acc, load_start, wr_last;
  logic           w_ready_c, a_ready_c;
  logic [K*W-1:0] r_q;
  logic           live;

  // Combinational outputs are forced low while reset is held.
  assign live = ~reset;

  mxu_weight_buffer #(.M(M), .K(K), .W(W)) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (w_acc),
    .restart  (state != LOAD_W),
    .row_data (bus.w_data),
    .weight   (mxu_weight),
    .wr_last  (wr_last)
  );

  always_comb begin
    state_nxt  = state;
    w_ready_c  = 1'b0;
    a_ready_c  = 1'b0;
    w_acc      = 1'b0;
    a_acc      = 1'b0;
    r_acc      = 1'b0;
    load_start = 1'b0;
    lat_last   = 1'b0;
    case (state)
      IDLE: begin
        w_ready_c = 1'b1;
        if (bus.w_valid) begin
          w_acc      = 1'b1;
          load_start = 1'b1;
          state_nxt  = wr_last ? READY : LOAD_W;
        end
      end
      LOAD_W: begin
        w_ready_c = 1'b1;
        if (bus.w_valid) begin
          w_acc = 1'b1;
          if (wr_last) state_nxt = READY;
        end
      end
      READY: begin
        // Activation has priority when both streams present a beat.
        a_ready_c = weights_valid;
        w_ready_c = ~bus.a_valid;
        if (bus.a_valid && weights_valid) begin
          a_acc     = 1'b1;
          state_nxt = COMPUTE;
        end else if (bus.w_valid && !bus.a_valid) begin
          w_acc      = 1'b1;
          load_start = 1'b1;
          state_nxt  = wr_last ? READY : LOAD_W;
        end
      end
      COMPUTE: begin
        lat_last = (lat_cnt == LW'(MXU_LATENCY - 1));
        if (lat_last) state_nxt = RESULT;
      end
      RESULT: begin
        if (bus.r_ready) begin
          r_acc     = 1'b1;
          state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      lat_cnt            <= '0;
      weights_valid      <= 1'b0;
      mxu_input_data     <= '0;
      r_q                <= '0;
      mxu_data_type      <= '0;
      mxu_enable_fp_unit <= '0;
    end else begin
      state <= state_nxt;
      if (load_start) begin
        weights_valid      <= 1'b0;
        mxu_data_type      <= cfg_data_type;
        mxu_enable_fp_unit <= cfg_fp_unit;
      end
      if (w_acc && wr_last) weights_valid <= 1'b1;
      if (a_acc) begin
        mxu_input_data <= bus.a_data;
        lat_cnt        <= '0;
      end else if (state == COMPUTE) begin
        lat_cnt <= lat_cnt + LW'(1);
      end
      if (lat_last) r_q <= mxu_y;
    end
  end

  assign bus.w_ready       = w_ready_c & live;
  assign bus.a_ready       = a_ready_c & live;
  assign bus.r_valid       = (state == RESULT) & live;
  assign bus.r_data        = r_q;
  assign mxu_enable        = (state == COMPUTE) & live;
  assign mxu_enable_in_ff  = mxu_enable;
  assign mxu_enable_out_ff = mxu_enable;
  assign mxu_enable_chain  = 1'b0;
  assign mxu_test_mode     = 1'b0;

`ifdef MXU_FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (r_acc && perf_ops != '1) perf_ops <= perf_ops + 32'd1;
      if ((state == COMPUTE || state == RESULT) && perf_busy != '1)
        perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mxu_feeder.sv
// Randomized bench for mxu_feeder with a behavioural MXU stand-in and a matrix-level reference model.
module tb_mxu_feeder;
  import mxu_pkg::*;

  localparam int M   = 3;
  localparam int K   = 3;
  localparam int W   = 64;
  localparam int LAT = 3;
  localparam int PW  = LOG_ALLOWED_PRECISIONS;
  localparam logic [PW-1:0] PREC_INT8 = PW'(1);

  logic                clk = 1'b0;
  logic                reset;
  logic [PW-1:0]       cfg_data_type, mxu_data_type;
  logic [1:0]          cfg_fp_unit, mxu_enable_fp_unit;
  logic                mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff, mxu_enable_chain;
  logic                mxu_test_mode;
  logic [M*W-1:0]      mxu_input_data;
  logic [M*K*W-1:0]    mxu_weight;
  logic [K*W-1:0]      mxu_y;
`ifdef MXU_FEEDER_PERF_EN
  logic [31:0]         perf_ops, perf_busy;
`endif

  mxu_feeder_if #(.M(M), .K(K), .W(W)) bus ();

  mxu_feeder #(.M(M), .K(K), .MAX_DATA_WIDTH(W), .MXU_LATENCY(LAT)) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_data_type      (cfg_data_type),
    .cfg_fp_unit        (cfg_fp_unit),
    .bus                (bus),
    .mxu_data_type      (mxu_data_type),
    .mxu_enable         (mxu_enable),
    .mxu_enable_in_ff   (mxu_enable_in_ff),
    .mxu_enable_out_ff  (mxu_enable_out_ff),
    .mxu_enable_chain   (mxu_enable_chain),
    .mxu_enable_fp_unit (mxu_enable_fp_unit),
    .mxu_test_mode      (mxu_test_mode),
    .mxu_input_data     (mxu_input_data),
    .mxu_weight         (mxu_weight),
    .mxu_y              (mxu_y)
`ifdef MXU_FEEDER_PERF_EN
    ,
    .perf_ops           (perf_ops),
    .perf_busy          (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [K*W-1:0] mw [M];
  logic [PW-1:0]  m_dt;
  logic [1:0]     m_fp;
  bit             m_loading, m_wv;
  int             m_row;
  logic [K*W-1:0] last_r;

  // INT8 mat-vec: y[k] = sum_i a[i] * w[i][k], low byte of each lane, signed, 64-bit result.
  function automatic logic [K*W-1:0] matvec(input logic [M*K*W-1:0] wt, input logic [M*W-1:0] act);
    logic [K*W-1:0] y;
    longint s;
    byte av, wv;
    y = '0;
    for (int k = 0; k < K; k++) begin
      s = 0;
      for (int i = 0; i < M; i++) begin
        av = act[i*W +: 8];
        wv = wt[i*K*W + k*W +: 8];
        s  = s + longint'(av) * longint'(wv);
      end
      y[k*W +: W] = s;
    end
    return y;
  endfunction

  function automatic logic [M*K*W-1:0] pack_w();
    logic [M*K*W-1:0] v;
    for (int i = 0; i < M; i++) v[i*K*W +: K*W] = mw[i];
    return v;
  endfunction

  function automatic logic [K*W-1:0] rnd_row();
    logic [K*W-1:0] v;
    for (int k = 0; k < K; k++) v[k*W +: W] = {$urandom, $urandom};
    return v;
  endfunction

  function automatic logic [M*W-1:0] rnd_act();
    logic [M*W-1:0] v;
    for (int i = 0; i < M; i++) v[i*W +: W] = {$urandom, $urandom};
    return v;
  endfunction

  // MXU stand-in: y is only meaningful on the LAT-th consecutive enabled cycle.
  int en_run;
  always_ff @(posedge clk) begin
    if (reset || !mxu_enable) en_run <= 0;
    else                      en_run <= en_run + 1;
  end

  always_comb begin
    mxu_y = {K{64'hDEAD_BEEF_0BAD_F00D}};
    if (mxu_enable && mxu_enable_in_ff && mxu_enable_out_ff && en_run == LAT - 1)
      mxu_y = matvec(mxu_weight, mxu_input_data);
  end

  task automatic chk(input string tag, input logic [M*K*W-1:0] got, input logic [M*K*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_data_type = PW'($urandom);
    cfg_fp_unit   = 2'($urandom);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    bus.r_ready = 1'b0;
    tick();
    tick();
    #2;
    chk("rst_w_ready", bus.w_ready, 0);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_enables", {mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff, mxu_enable_chain, mxu_test_mode}, 0);
    chk("rst_weight", mxu_weight, 0);
    chk("rst_input", mxu_input_data, 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_cfg", {mxu_data_type, mxu_enable_fp_unit}, 0);
    reset = 1'b0;
    for (int i = 0; i < M; i++) mw[i] = '0;
    m_dt = '0; m_fp = '0; m_loading = 0; m_wv = 0; m_row = 0;
    tick();
    #2;
    chk("post_rst_w_ready", bus.w_ready, 1);
    chk("post_rst_a_ready", bus.a_ready, 0);
  endtask

  task automatic send_row(input logic [K*W-1:0] d);
    bus.w_valid = 1'b1;
    bus.w_data  = d;
    #2;
    chk("w_ready", bus.w_ready, 1);
    chk("a_ready_load", bus.a_ready, m_wv && !m_loading);
    if (!m_loading) begin
      m_dt = cfg_data_type; m_fp = cfg_fp_unit;
      m_loading = 1; m_row = 0; m_wv = 0;
    end
    mw[m_row] = d;
    m_row++;
    if (m_row == M) begin m_loading = 0; m_row = 0; m_wv = 1; end
    tick();
    bus.w_valid = 1'b0;
  endtask

  task automatic check_loaded();
    #2;
    chk("weight", mxu_weight, pack_w());
    chk("a_ready_loaded", bus.a_ready, 1);
    chk("data_type", mxu_data_type, m_dt);
    chk("fp_unit", mxu_enable_fp_unit, m_fp);
  endtask

  task automatic compute(input logic [M*W-1:0] act, input int hold, input bit with_w);
    logic [K*W-1:0] exp_y;
    bus.a_valid = 1'b1;
    bus.a_data  = act;
    bus.w_valid = with_w;
    bus.w_data  = rnd_row();
    bus.r_ready = 1'b0;
    #2;
    chk("a_ready", bus.a_ready, 1);
    chk("w_ready_vs_a", bus.w_ready, 0);
    exp_y = matvec(pack_w(), act);
    tick();
    bus.a_valid = 1'b0;
    bus.w_valid = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      #2;
      chk("enables_on", {mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff, mxu_enable_chain}, 4'b1110);
      chk("r_valid_early", bus.r_valid, 0);
      chk("a_ready_busy", bus.a_ready, 0);
      if (c == 1) chk("input_data", mxu_input_data, act);
      tick();
    end
    for (int h = 0; h < hold; h++) begin
      bus.a_valid = 1'b1;
      bus.a_data  = rnd_act();
      bus.w_valid = 1'b1;
      #2;
      chk("r_valid_hold", bus.r_valid, 1);
      chk("r_data_hold", bus.r_data, exp_y);
      chk("rdy_backpressure", {bus.a_ready, bus.w_ready}, 0);
      chk("enables_off", {mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff}, 0);
      tick();
    end
    bus.r_ready = 1'b1;
    #2;
    chk("r_valid", bus.r_valid, 1);
    chk("r_data", bus.r_data, exp_y);
    chk("a_ready_result", bus.a_ready, 0);
    last_r = bus.r_data;
    tick();
    bus.r_ready = 1'b0;
    bus.a_valid = 1'b0;
    bus.w_valid = 1'b0;
    #2;
    chk("r_valid_drop", bus.r_valid, 0);
    chk("a_ready_back", bus.a_ready, 1);
    chk("weight_kept", mxu_weight, pack_w());
    chk("input_kept", mxu_input_data, act);
    chk("data_type_kept", mxu_data_type, m_dt);
  endtask

  initial begin
    logic [K*W-1:0] row_ff;
    logic [M*W-1:0] act_fe;
    logic [M*K*W-1:0] w_spec;
    logic [K*W-1:0] y_spec;
    row_ff = {K{56'd0, 8'hff}};
    act_fe = {M{56'd0, 8'hfe}};
    w_spec = {M*K{56'd0, 8'hff}};
    y_spec = {K{64'd6}};
    bus.w_data = '0;
    bus.a_data = '0;
    cfg_data_type = '0;
    cfg_fp_unit = '0;

    do_reset();

    // Directed: all -1 weights, all -2 activations.
    for (int r = 0; r < M; r++) begin
      cfg_data_type = PREC_INT8;
      send_row(row_ff);
    end
    check_loaded();
    chk("weight_spec", mxu_weight, w_spec);
    compute(act_fe, 10, 1'b0);
    chk("y_spec", last_r, y_spec);

    // Both streams valid in READY: activation wins, weights untouched.
    compute(rnd_act(), 1, 1'b1);

    // Randomized mix of reloads and operations.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int r = 0; r < M; r++) send_row(rnd_row());
        check_loaded();
      end else begin
        compute(rnd_act(), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of an operation.
    bus.a_valid = 1'b1;
    bus.a_data  = rnd_act();
    #2;
    chk("a_ready_pre_abort", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    tick();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("abort_r_valid", bus.r_valid, 0);
      chk("abort_a_ready", bus.a_ready, 0);
      chk("abort_enable", mxu_enable, 0);
      tick();
    end
    for (int r = 0; r < M; r++) send_row(rnd_row());
    check_loaded();
    compute(rnd_act(), 2, 1'b0);

    // Reset in the middle of a weight load.
    for (int r = 0; r < M - 1; r++) send_row(rnd_row());
    do_reset();
    for (int r = 0; r < M; r++) send_row(rnd_row());
    check_loaded();
    compute(rnd_act(), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
